// File: rtl/i2c_pkg.sv
// Shared types for the I2C read master: FSM states, bit-phase indices and the
// bus-level decode used to set SCL/SDA for a given state and phase.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_READ,
        ST_MACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_LOW    = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_HIGH   = 2'd3;

    localparam logic RW_READ = 1'b1;

    typedef struct packed {
        logic scl;
        logic own;
        logic low;
    } bus_t;

    // Pin levels for a phase of a bit; 'low' is the data-bit pull for ADDR/MACK.
    function automatic bus_t bus_level(state_t st, logic [1:0] ph, logic low);
        bus_t b;
        b = '{scl: 1'b1, own: 1'b0, low: 1'b0};
        case (st)
            ST_START: begin
                b.scl = (ph == PH_SETUP) || (ph == PH_LOW);
                b.own = 1'b1;
                b.low = (ph != PH_SETUP);
            end
            ST_ADDR, ST_MACK: begin
                b.scl = ph[1];
                b.own = 1'b1;
                b.low = low;
            end
            ST_ADDR_ACK, ST_READ: begin
                b.scl = ph[1];
            end
            ST_STOP: begin
                b.scl = ph[1];
                b.own = 1'b1;
                b.low = (ph != PH_HIGH);
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit phase generator: divides clk_200kHz into four SCL phases of
// CLK_DIV cycles each, with a strobe on the last cycle of every phase.
module i2c_phase_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk_200kHz,
    input  logic       reset,
    input  logic       run,
    output logic [1:0] phase,
    output logic       end_ph
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign end_ph = run && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_200kHz or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (end_ph) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_read_master.sv
// I2C read master: START, address with R/W=1, 1..MAX_BYTES data bytes with
// master ACK/NACK, STOP, then a done pulse with the bytes left-aligned.
module i2c_read_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV   = 5,
    parameter int         MAX_BYTES = 2,
    parameter logic [6:0] DEV_ADDR  = 7'h4B,
    parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_200kHz,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_bytes,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    inout  wire                    SDA,
    output logic                   SDA_dir,
    output logic                   SCL
);

    localparam int         RD_W      = 8 * MAX_BYTES;
    localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, RW_READ};

    state_t           state;
    logic [1:0]       phase;
    logic             end_ph;
    logic             run;
    logic             end_bit;
    logic             smp;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] byte_idx;
    logic             last_byte;
    logic [7:0]       shreg;
    logic [RD_W-1:0]  rx_buf;
    logic             sda_low;
    logic             sda_in;
    logic             sda_smp;

    // Open-drain: only ever pull low, otherwise leave the line to the pull-up.
    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;

    assign run       = (state != ST_IDLE) && (state != ST_DONE);
    assign end_bit   = end_ph && (phase == PH_HIGH);
    assign smp       = end_ph && (phase == PH_SAMPLE);
    assign last_byte = (byte_idx == n_lat - CNT_W'(1));
    assign n_eff     = (num_bytes == '0) ? CNT_W'(1) :
                       (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;

    i2c_phase_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_gen (
        .clk_200kHz(clk_200kHz),
        .reset     (reset),
        .run       (run),
        .phase     (phase),
        .end_ph    (end_ph)
    );

    // Pin registers are loaded with the level of the phase about to begin,
    // so SCL/SDA change exactly on phase boundaries.
    always_ff @(posedge clk_200kHz or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            SCL      <= 1'b1;
            SDA_dir  <= 1'b0;
            sda_low  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rd_data  <= '0;
            n_lat    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_buf   <= '0;
            sda_smp  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (end_ph && (phase != PH_HIGH))
                {SCL, SDA_dir, sda_low} <= bus_level(state, phase + 2'd1, sda_low);
            if (smp)
                sda_smp <= sda_in;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_START;
                        busy     <= 1'b1;
                        ack_err  <= 1'b0;
                        n_lat    <= n_eff;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        shreg    <= ADDR_BYTE;
                        rx_buf   <= '0;
                        {SCL, SDA_dir, sda_low} <= bus_level(ST_START, PH_SETUP, 1'b0);
                    end
                end
                ST_START: begin
                    if (end_bit) begin
                        state <= ST_ADDR;
                        {SCL, SDA_dir, sda_low} <= bus_level(ST_ADDR, PH_SETUP, ~shreg[7]);
                    end
                end
                ST_ADDR: begin
                    if (end_bit) begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        if (bit_idx == 3'd7) begin
                            state <= ST_ADDR_ACK;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_ADDR_ACK, PH_SETUP, 1'b0);
                        end else begin
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_ADDR, PH_SETUP, ~shreg[6]);
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (end_bit) begin
                        if (sda_smp) begin
                            ack_err <= 1'b1;
                            state   <= ST_STOP;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_STOP, PH_SETUP, 1'b1);
                        end else begin
                            state <= ST_READ;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_READ, PH_SETUP, 1'b0);
                        end
                    end
                end
                ST_READ: begin
                    if (smp)
                        shreg <= {shreg[6:0], sda_in};
                    if (end_bit) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_MACK;
                            // Byte 0 lands in the top lane of the staging buffer.
                            for (int i = 0; i < MAX_BYTES; i++)
                                if (byte_idx == CNT_W'(MAX_BYTES - 1 - i))
                                    rx_buf[8*i +: 8] <= shreg;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_MACK, PH_SETUP, ~last_byte);
                        end else begin
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_READ, PH_SETUP, 1'b0);
                        end
                    end
                end
                ST_MACK: begin
                    if (end_bit) begin
                        if (sda_low) begin
                            byte_idx <= byte_idx + CNT_W'(1);
                            state    <= ST_READ;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_READ, PH_SETUP, 1'b0);
                        end else begin
                            state <= ST_STOP;
                            {SCL, SDA_dir, sda_low} <= bus_level(ST_STOP, PH_SETUP, 1'b1);
                        end
                    end
                end
                ST_STOP: begin
                    if (end_bit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (!ack_err)
                            rd_data <= rx_buf;
                        {SCL, SDA_dir, sda_low} <= bus_level(ST_DONE, PH_SETUP, 1'b0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
